// File: rtl/stage_4_pkg.sv
// Shared opcode/func_3 constants and load/store lane helpers for the memory stage.
package stage_4_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } store_lanes_t;

  // Unsigned byte/half codes exist only for loads; any other code is a word access.
  function automatic size_e access_size(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B:    return SZ_BYTE;
      F3_H:    return SZ_HALF;
      F3_BU:   return is_store ? SZ_WORD : SZ_BYTE;
      F3_HU:   return is_store ? SZ_WORD : SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic store_lanes_t store_lanes(input size_e sz, input logic [1:0] lane,
                                               input logic [31:0] data);
    store_lanes_t s;
    case (sz)
      SZ_BYTE: begin
        s.be    = 4'b0001 << lane;
        s.wdata = {4{data[7:0]}};
      end
      SZ_HALF: begin
        s.be    = 4'b0011 << {lane[1], 1'b0};
        s.wdata = {2{data[15:0]}};
      end
      default: begin
        s.be    = 4'b1111;
        s.wdata = data;
      end
    endcase
    return s;
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode, input logic [4:0] rd);
    return (rd != 5'd0) && (opcode != OP_STORE) && (opcode != OP_BRANCH);
  endfunction

endpackage

// File: rtl/stage_4_if.sv
// Word-addressed data-memory bus: request held stable until ack, rdata valid with ack.
interface stage_4_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/stage_4_load_format.sv
// Selects the addressed byte/half lane of a load word and sign- or zero-extends it.
module stage_4_load_format
  import stage_4_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  func_3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{lane, 3'b000} +: 8];
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
    case (func_3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'h0, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'h0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/stage_4.sv
// Memory stage: ALU results pass through in one cycle; loads/stores run a
// held request/ack handshake on the data bus and write back from RESP.
module stage_4
  import stage_4_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic        i_op_type,
  stage_4_if.master   mem,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd_num,
  output logic [31:0] wb_data,
  output logic        o_misaligned,
  output logic        o_stall
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e       state, state_n;
  logic         accept, is_store_in, mis_in, ls_go;
  size_e        sz_in;
  store_lanes_t lanes_in;

  logic [31:0]  addr_q, wdata_q, load_data;
  logic [3:0]   be_q;
  logic         we_q;
  logic [2:0]   func3_q;
  logic [6:0]   opcode_q;
  logic [4:0]   rd_q;

  // RESP is a writeback-only cycle, so a new instruction is taken there too.
  assign accept      = i_valid && (state != REQ);
  assign is_store_in = (i_opcode == OP_STORE);
  assign sz_in       = access_size(is_store_in, i_func_3);
  assign mis_in      = i_op_type && misaligned(sz_in, i_alu_out[1:0]);
  assign ls_go       = accept && i_op_type && !mis_in;
  assign lanes_in    = store_lanes(sz_in, i_alu_out[1:0], i_rs_2);

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_n   = state;
    o_stall   = 1'b0;
    mem.req   = 1'b0;
    mem.we    = 1'b0;
    mem.addr  = 32'h0;
    mem.wdata = 32'h0;
    mem.be    = 4'h0;
    case (state)
      IDLE, RESP: begin
        o_stall = ls_go;
        state_n = ls_go ? REQ : IDLE;
      end
      REQ: begin
        o_stall   = 1'b1;
        mem.req   = 1'b1;
        mem.we    = we_q;
        mem.addr  = {addr_q[31:2], 2'b00};
        mem.wdata = wdata_q;
        mem.be    = be_q;
        if (mem.ack) state_n = RESP;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
      we_q     <= 1'b0;
      func3_q  <= 3'h0;
      opcode_q <= 7'h0;
      rd_q     <= 5'h0;
    end else if (ls_go) begin
      addr_q   <= i_alu_out;
      wdata_q  <= is_store_in ? lanes_in.wdata : 32'h0;
      be_q     <= is_store_in ? lanes_in.be : 4'b1111;
      we_q     <= is_store_in;
      func3_q  <= i_func_3;
      opcode_q <= i_opcode;
      rd_q     <= i_rd_num;
    end
  end

  stage_4_load_format u_load_format (
    .rdata  (mem.rdata),
    .lane   (addr_q[1:0]),
    .func_3 (func3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd_num    <= 5'h0;
      wb_data      <= 32'h0;
      o_misaligned <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      o_misaligned <= 1'b0;
      if (state == REQ && mem.ack) begin
        wb_valid  <= 1'b1;
        wb_rd_num <= rd_q;
        wb_data   <= we_q ? 32'h0 : load_data;
        wb_we     <= writes_rd(opcode_q, rd_q);
      end else if (accept && !ls_go) begin
        // Pass-through covers both ALU results and misaligned accesses.
        wb_valid     <= 1'b1;
        wb_rd_num    <= i_rd_num;
        wb_data      <= i_alu_out;
        wb_we        <= writes_rd(i_opcode, i_rd_num) && !mis_in;
        o_misaligned <= mis_in;
      end
    end
  end

endmodule

// File: tb/tb_stage_4.sv
// Randomized + directed bench for stage_4 against a transaction-level model.
module tb_stage_4;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_op_type;
  logic [31:0] i_alu_out, i_rs_2;
  logic [4:0]  i_rd_num;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func_3;
  logic        wb_valid, wb_we, o_misaligned, o_stall;
  logic [4:0]  wb_rd_num;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stage_4_if mem ();

  stage_4 dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .i_alu_out    (i_alu_out),
    .i_rs_2       (i_rs_2),
    .i_rd_num     (i_rd_num),
    .i_opcode     (i_opcode),
    .i_func_3     (i_func_3),
    .i_op_type    (i_op_type),
    .mem          (mem),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_rd_num    (wb_rd_num),
    .wb_data      (wb_data),
    .o_misaligned (o_misaligned),
    .o_stall      (o_stall)
  );

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        op_type;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    bit          mem_op;
    bit          mis;
    bit          store;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
    bit          we;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected behaviour from access width in bytes and plain shift/mask arithmetic.
  function automatic exp_t model(input instr_t in, input logic [31:0] rdata);
    exp_t e;
    int unsigned bytes, off;
    logic [31:0] mask, v;
    e.store = (in.opcode == T_STORE);
    e.mem_op = in.op_type;
    if (in.f3 == 3'd0 || (!e.store && in.f3 == 3'd4))      bytes = 1;
    else if (in.f3 == 3'd1 || (!e.store && in.f3 == 3'd5)) bytes = 2;
    else                                                   bytes = 4;
    off     = in.addr % 4;
    e.mis   = in.op_type && ((in.addr % bytes) != 0);
    e.maddr = in.addr & ~32'd3;
    e.be    = e.store ? 4'(((1 << bytes) - 1) << off) : 4'hF;
    if (bytes == 1)      e.wdata = in.rs2[7:0] * 32'h0101_0101;
    else if (bytes == 2) e.wdata = in.rs2[15:0] * 32'h0001_0001;
    else                 e.wdata = in.rs2;
    mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 1);
    v = (rdata >> (8 * off)) & mask;
    if (bytes < 4 && in.f3 < 3'd4 && v[8 * bytes - 1]) v = v | ~mask;
    e.data = (in.op_type && !e.mis) ? v : in.addr;
    e.we = (in.rd != 0) && (in.opcode != T_STORE) && (in.opcode != T_BRANCH) && !e.mis;
    return e;
  endfunction

  task automatic drive(input instr_t in);
    i_valid   = 1'b1;
    i_opcode  = in.opcode;
    i_func_3  = in.f3;
    i_op_type = in.op_type;
    i_alu_out = in.addr;
    i_rs_2    = in.rs2;
    i_rd_num  = in.rd;
  endtask

  task automatic idle_inputs();
    i_valid   = 1'b0;
    i_opcode  = 7'h0;
    i_func_3  = 3'h0;
    i_op_type = 1'b0;
    i_alu_out = 32'h0;
    i_rs_2    = 32'h0;
    i_rd_num  = 5'h0;
  endtask

  task automatic check_wb(input instr_t in, input exp_t e);
    check("wb_valid", wb_valid, 1'b1);
    check("wb_rd_num", wb_rd_num, in.rd);
    check("wb_we", wb_we, e.we);
    check("o_misaligned", o_misaligned, e.mis);
    if (!e.store || e.mis) check("wb_data", wb_data, e.data);
  endtask

  task automatic check_req(input exp_t e);
    check("mem_req", mem.req, 1'b1);
    check("mem_we", mem.we, e.store);
    check("mem_addr", mem.addr, e.maddr);
    check("mem_be", mem.be, e.be);
    if (e.store) check("mem_wdata", mem.wdata, e.wdata);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, mem.req, 1'b0);
    check({tag, "_we"}, mem.we, 1'b0);
    check({tag, "_be"}, mem.be, 4'h0);
    check({tag, "_addr"}, mem.addr, 32'h0);
    check({tag, "_wdata"}, mem.wdata, 32'h0);
    check({tag, "_wbv"}, wb_valid, 1'b0);
    check({tag, "_wbwe"}, wb_we, 1'b0);
    check({tag, "_wbrd"}, wb_rd_num, 5'h0);
    check({tag, "_wbdata"}, wb_data, 32'h0);
    check({tag, "_mis"}, o_misaligned, 1'b0);
    check({tag, "_stall"}, o_stall, 1'b0);
  endtask

  // Issue one instruction; memory acks in REQ cycle index `lat`. Returns observed stall cycles.
  task automatic run_instr(input instr_t in, input int lat, input logic [31:0] rdata,
                           output int stalls);
    exp_t e;
    e = model(in, rdata);
    stalls = 0;
    @(negedge clk);
    drive(in);
    mem.ack = 1'b0;
    #1;
    check("stall_issue", o_stall, e.mem_op && !e.mis);
    check("req_issue", mem.req, 1'b0);
    if (o_stall) stalls++;
    if (e.mem_op && !e.mis) begin
      for (int k = 0; k <= lat; k++) begin
        @(negedge clk);
        if (k == 0) idle_inputs();
        #1;
        check_req(e);
        check("stall_req", o_stall, 1'b1);
        check("wbv_req", wb_valid, 1'b0);
        if (o_stall) stalls++;
        if (k == lat) begin
          mem.ack   = 1'b1;
          mem.rdata = rdata;
        end
      end
      @(negedge clk);
      mem.ack   = 1'b0;
      mem.rdata = $urandom;
      #1;
      check_wb(in, e);
      check("req_resp", mem.req, 1'b0);
      check("stall_resp", o_stall, 1'b0);
      check("stall_cnt", stalls, lat + 2);
    end else begin
      @(negedge clk);
      idle_inputs();
      #1;
      check_wb(in, e);
      check("req_alu", mem.req, 1'b0);
    end
  endtask

  instr_t in, in2;
  exp_t   e1, e2;
  int     stalls;
  logic [31:0] rd_word;
  logic [6:0]  alu_ops [4] = '{T_OP, T_OPIMM, T_BRANCH, T_OP};

  initial begin
    reset = 1'b1;
    mem.ack = 1'b0;
    mem.rdata = 32'h0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;

    // Idle cycles produce nothing.
    @(negedge clk);
    #1;
    check("idle_wbv", wb_valid, 1'b0);
    check("idle_req", mem.req, 1'b0);

    // ALU pass-through.
    in = '{opcode: T_OP, f3: 3'd0, op_type: 1'b0, addr: 32'h0000_1234, rs2: 32'h0, rd: 5'd5};
    run_instr(in, 0, 32'h0, stalls);
    check("alu_data", wb_data, 32'h0000_1234);
    check("alu_we", wb_we, 1'b1);

    // LB from the top lane with a 3-cycle ack.
    in = '{opcode: T_LOAD, f3: 3'd0, op_type: 1'b1, addr: 32'h0000_0103, rs2: 32'h0, rd: 5'd7};
    run_instr(in, 2, 32'h80FF_0000, stalls);
    check("lb_data", wb_data, 32'hFFFF_FF80);
    check("lb_stall4", stalls, 4);

    // SH to upper half.
    in = '{opcode: T_STORE, f3: 3'd1, op_type: 1'b1, addr: 32'h0000_0102, rs2: 32'hDEAD_BEEF, rd: 5'd3};
    @(negedge clk);
    drive(in);
    @(negedge clk);
    idle_inputs();
    #1;
    check("sh_addr", mem.addr, 32'h0000_0100);
    check("sh_be", mem.be, 4'b1100);
    check("sh_wdata", mem.wdata, 32'hBEEF_BEEF);
    check("sh_we", mem.we, 1'b1);
    mem.ack = 1'b1;
    @(negedge clk);
    mem.ack = 1'b0;
    #1;
    check("sh_wbv", wb_valid, 1'b1);
    check("sh_wbwe", wb_we, 1'b0);

    // Misaligned LW skips memory.
    in = '{opcode: T_LOAD, f3: 3'd2, op_type: 1'b1, addr: 32'h0000_0101, rs2: 32'h0, rd: 5'd9};
    run_instr(in, 0, 32'h0, stalls);
    check("lw_mis", o_misaligned, 1'b1);
    check("lw_mis_we", wb_we, 1'b0);

    // Reset in REQ, late ack after release.
    in = '{opcode: T_LOAD, f3: 3'd0, op_type: 1'b1, addr: 32'h0000_0040, rs2: 32'h0, rd: 5'd4};
    @(negedge clk);
    drive(in);
    @(negedge clk);
    idle_inputs();
    #1;
    check("rq_req", mem.req, 1'b1);
    reset = 1'b1;
    #1;
    check_all_zero("rq_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    mem.ack = 1'b1;
    mem.rdata = 32'h1234_5678;
    @(negedge clk);
    mem.ack = 1'b0;
    #1;
    check("late_ack_wbv", wb_valid, 1'b0);
    check("late_ack_req", mem.req, 1'b0);
    @(negedge clk);
    #1;
    check("late_ack_wbv2", wb_valid, 1'b0);

    // Back-to-back: LW with zero-wait ack, ADD accepted in RESP.
    in  = '{opcode: T_LOAD, f3: 3'd2, op_type: 1'b1, addr: 32'h0000_0200, rs2: 32'h0, rd: 5'd10};
    in2 = '{opcode: T_OP, f3: 3'd0, op_type: 1'b0, addr: 32'h0BAD_F00D, rs2: 32'h0, rd: 5'd11};
    rd_word = $urandom;
    e1 = model(in, rd_word);
    e2 = model(in2, 32'h0);
    @(negedge clk);
    drive(in);
    #1;
    check("b2b_stall", o_stall, 1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    check_req(e1);
    mem.ack = 1'b1;
    mem.rdata = rd_word;
    @(negedge clk);
    mem.ack = 1'b0;
    drive(in2);
    #1;
    check_wb(in, e1);
    check("b2b_resp_stall", o_stall, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    check_wb(in2, e2);
    @(negedge clk);
    #1;
    check("b2b_after", wb_valid, 1'b0);

    // Random mix of ALU ops, loads and stores.
    for (int n = 0; n < 80; n++) begin
      in.rd  = 5'($urandom_range(0, 31));
      in.f3  = 3'($urandom);
      in.rs2 = $urandom;
      in.addr = $urandom & 32'h0000_FFFF;
      case ($urandom_range(0, 2))
        0: begin in.opcode = alu_ops[$urandom_range(0, 3)]; in.op_type = 1'b0; end
        1: begin in.opcode = T_LOAD;  in.op_type = 1'b1; end
        default: begin in.opcode = T_STORE; in.op_type = 1'b1; end
      endcase
      run_instr(in, $urandom_range(0, 3), $urandom, stalls);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
